tlul_host_adapter: RTL

- TileLink-UL initiator (master): converts a simple request/response port into TL-UL A-channel requests and D-channel responses.
- Sits between a core-side client (fetch, LSU, DMA) and a TL-UL slave such as the platform interrupt controller.
- Supports up to 2**TL_RS outstanding transactions, each tagged with a distinct a_source.
- Checks every D response against its recorded request and reports errors.

---
 rtl/tlul_pkg.sv | 33 +++
 rtl/tlul_host_adapter_if.sv | 69 ++++++
 rtl/tlul_source_alloc.sv | 66 ++++++
 rtl/tlul_host_adapter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: opcode encodings and byte-mask helpers.
package tlul_pkg;

  localparam int unsigned OPW = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned MW  = 4;

  localparam logic [OPW-1:0] A_GET         = 3'd4;
  localparam logic [OPW-1:0] A_PUT_FULL    = 3'd0;
  localparam logic [OPW-1:0] A_PUT_PARTIAL = 3'd1;

  localparam logic [OPW-1:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [OPW-1:0] D_ACCESS_ACK_DATA = 3'd1;

  // Byte lanes covered by a naturally aligned access of 2**size bytes at addr_lo
  function automatic logic [MW-1:0] full_mask(input logic [3:0] size, input logic [1:0] addr_lo);
    case (size)
      4'd0:    return 4'b0001 << addr_lo;
      4'd1:    return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // True when addr_lo is aligned to 2**size bytes
  function automatic logic is_aligned(input logic [3:0] size, input logic [1:0] addr_lo);
    case (size)
      4'd0:    return 1'b1;
      4'd1:    return ~addr_lo[0];
      default: return addr_lo == 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/tlul_host_adapter_if.sv
// Client request/response port plus TL-UL A/D channels of the host adapter.
interface tlul_host_adapter_if #(
  parameter int unsigned TL_RS = 4,
  parameter int unsigned AW    = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AW-1:0]    req_address;
  logic [3:0]       req_size;
  logic [3:0]       req_mask;
  logic [31:0]      req_data;
  logic [TL_RS-1:0] req_tag;

  logic [2:0]       tlm_a_opcode;
  logic [2:0]       tlm_a_param;
  logic [3:0]       tlm_a_size;
  logic [TL_RS-1:0] tlm_a_source;
  logic [AW-1:0]    tlm_a_address;
  logic [3:0]       tlm_a_mask;
  logic [31:0]      tlm_a_data;
  logic             tlm_a_corrupt;
  logic             tlm_a_valid;
  logic             tlm_a_ready;

  logic [2:0]       tlm_d_opcode;
  logic [1:0]       tlm_d_param;
  logic [3:0]       tlm_d_size;
  logic [TL_RS-1:0] tlm_d_source;
  logic             tlm_d_denied;
  logic [31:0]      tlm_d_data;
  logic             tlm_d_corrupt;
  logic             tlm_d_valid;
  logic             tlm_d_ready;

  logic             resp_valid;
  logic             resp_ready;
  logic [TL_RS-1:0] resp_tag;
  logic [31:0]      resp_data;
  logic             resp_error;

  // Adapter side: TL-UL initiator
  modport master (
    input  req_valid, req_write, req_address, req_size, req_mask, req_data,
    output req_ready, req_tag,
    output tlm_a_opcode, tlm_a_param, tlm_a_size, tlm_a_source, tlm_a_address,
    output tlm_a_mask, tlm_a_data, tlm_a_corrupt, tlm_a_valid,
    input  tlm_a_ready,
    input  tlm_d_opcode, tlm_d_param, tlm_d_size, tlm_d_source, tlm_d_denied,
    input  tlm_d_data, tlm_d_corrupt, tlm_d_valid,
    output tlm_d_ready,
    output resp_valid, resp_tag, resp_data, resp_error,
    input  resp_ready
  );

  // Environment side: client and TL-UL target
  modport slave (
    output req_valid, req_write, req_address, req_size, req_mask, req_data,
    input  req_ready, req_tag,
    input  tlm_a_opcode, tlm_a_param, tlm_a_size, tlm_a_source, tlm_a_address,
    input  tlm_a_mask, tlm_a_data, tlm_a_corrupt, tlm_a_valid,
    output tlm_a_ready,
    output tlm_d_opcode, tlm_d_param, tlm_d_size, tlm_d_source, tlm_d_denied,
    output tlm_d_data, tlm_d_corrupt, tlm_d_valid,
    input  tlm_d_ready,
    input  resp_valid, resp_tag, resp_data, resp_error,
    output resp_ready
  );
endinterface

// File: rtl/tlul_source_alloc.sv
// Source-ID allocator: pending bitmap, lowest-free encoder, expected D opcode per source.
module tlul_source_alloc
  import tlul_pkg::*;
#(
  parameter int unsigned TL_RS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_i,
  input  logic [OPW-1:0]   set_op_i,
  input  logic             clr_i,
  input  logic [TL_RS-1:0] clr_idx_i,
  input  logic             flush_i,
  input  logic [TL_RS-1:0] look_idx_i,
  output logic [TL_RS-1:0] alloc_idx_o,
  output logic             any_free_o,
  output logic             look_pend_o,
  output logic [OPW-1:0]   look_op_o,
  output logic             pend_any_o
);

  localparam int unsigned NS = 1 << TL_RS;

  logic [NS-1:0]  pend_q, pend_d;
  logic [OPW-1:0] exp_op_q [NS];
  logic [OPW-1:0] exp_op_d [NS];

  // Lowest-index free source from the bitmap as it stood at the start of the cycle
  always_comb begin
    alloc_idx_o = '0;
    any_free_o  = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (!pend_q[i]) begin
        alloc_idx_o = TL_RS'(i);
        any_free_o  = 1'b1;
      end
    end
  end

  // Timeout flush drops old entries; a same-cycle allocation still lands
  always_comb begin
    pend_d   = flush_i ? '0 : pend_q;
    exp_op_d = exp_op_q;
    if (clr_i) pend_d[clr_idx_i] = 1'b0;
    if (set_i && any_free_o) begin
      pend_d[alloc_idx_o]   = 1'b1;
      exp_op_d[alloc_idx_o] = set_op_i;
    end
  end

  // Bitmap and expected-opcode table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      for (int i = 0; i < NS; i++) exp_op_q[i] <= '0;
    end else begin
      pend_q   <= pend_d;
      exp_op_q <= exp_op_d;
    end
  end

  assign look_pend_o = pend_q[look_idx_i];
  assign look_op_o   = exp_op_q[look_idx_i];
  assign pend_any_o  = |pend_q;

endmodule

// File: rtl/tlul_host_adapter.sv
// TL-UL host adapter: client requests -> A channel, D channel -> client responses.
// Optional watchdog enabled by defining TLM_TIMEOUT_EN (adds timeout_o).
module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned TL_RS          = 4,
  parameter int unsigned AW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic tlm_clock_i,
  input  logic tlm_reset_i,
  tlul_host_adapter_if.master bus,
`ifdef TLM_TIMEOUT_EN
  output logic timeout_o,
`endif
  output logic proto_err_o
);

  logic             a_valid_q, a_valid_d;
  logic [OPW-1:0]   a_opcode_q, a_opcode_d;
  logic [3:0]       a_size_q, a_size_d;
  logic [TL_RS-1:0] a_source_q, a_source_d;
  logic [AW-1:0]    a_address_q, a_address_d;
  logic [MW-1:0]    a_mask_q, a_mask_d;
  logic [DW-1:0]    a_data_q, a_data_d;

  logic             resp_valid_q, resp_valid_d;
  logic [TL_RS-1:0] resp_tag_q, resp_tag_d;
  logic [DW-1:0]    resp_data_q, resp_data_d;
  logic             resp_error_q, resp_error_d;
  logic             proto_err_q, proto_err_d;
  logic             live_q;

  logic [TL_RS-1:0] alloc_idx;
  logic             any_free, look_pend, pend_any, flush;
  logic [OPW-1:0]   look_op, req_op;
  logic             accept, d_fire, d_hit;
  logic             unused_d;

  assign unused_d = ^{bus.tlm_d_param, bus.tlm_d_size};

  assign bus.req_ready = any_free & (~a_valid_q | bus.tlm_a_ready);
  assign bus.req_tag   = alloc_idx;
  assign accept        = bus.req_valid & bus.req_ready;

  // live_q holds d_ready low while in reset; response register is one entry deep
  assign bus.tlm_d_ready = live_q & (~resp_valid_q | bus.resp_ready);
  assign d_fire          = bus.tlm_d_valid & bus.tlm_d_ready;
  assign d_hit           = d_fire & look_pend;

  // A opcode: Get, or PutFull only for an aligned access with every lane enabled
  always_comb begin
    req_op = A_GET;
    if (bus.req_write) begin
      if (is_aligned(bus.req_size, bus.req_address[1:0]) &&
          bus.req_mask == full_mask(bus.req_size, bus.req_address[1:0]))
        req_op = A_PUT_FULL;
      else
        req_op = A_PUT_PARTIAL;
    end
  end

  tlul_source_alloc #(.TL_RS(TL_RS)) u_alloc (
    .clk         (tlm_clock_i),
    .rst         (tlm_reset_i),
    .set_i       (accept),
    .set_op_i    (bus.req_write ? D_ACCESS_ACK : D_ACCESS_ACK_DATA),
    .clr_i       (d_hit),
    .clr_idx_i   (bus.tlm_d_source),
    .flush_i     (flush),
    .look_idx_i  (bus.tlm_d_source),
    .alloc_idx_o (alloc_idx),
    .any_free_o  (any_free),
    .look_pend_o (look_pend),
    .look_op_o   (look_op),
    .pend_any_o  (pend_any)
  );

  // Next-state for the A register, response register and protocol-error flag
  always_comb begin
    a_valid_d    = a_valid_q;
    a_opcode_d   = a_opcode_q;
    a_size_d     = a_size_q;
    a_source_d   = a_source_q;
    a_address_d  = a_address_q;
    a_mask_d     = a_mask_q;
    a_data_d     = a_data_q;
    resp_valid_d = resp_valid_q;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    proto_err_d  = proto_err_q | (d_fire & ~look_pend);

    if (accept) begin
      a_valid_d   = 1'b1;
      a_opcode_d  = req_op;
      a_size_d    = bus.req_size;
      a_source_d  = alloc_idx;
      a_address_d = bus.req_address;
      a_mask_d    = bus.req_mask;
      a_data_d    = bus.req_data;
    end else if (bus.tlm_a_ready) begin
      a_valid_d = 1'b0;
    end

    if (resp_valid_q && bus.resp_ready) resp_valid_d = 1'b0;
    if (d_hit) begin
      resp_valid_d = 1'b1;
      resp_tag_d   = bus.tlm_d_source;
      resp_data_d  = (bus.tlm_d_opcode == D_ACCESS_ACK_DATA) ? bus.tlm_d_data : '0;
      resp_error_d = bus.tlm_d_denied | bus.tlm_d_corrupt | (bus.tlm_d_opcode != look_op);
    end
  end

  // Datapath and status registers
  always_ff @(posedge tlm_clock_i or posedge tlm_reset_i) begin
    if (tlm_reset_i) begin
      a_valid_q    <= 1'b0;
      a_opcode_q   <= '0;
      a_size_q     <= '0;
      a_source_q   <= '0;
      a_address_q  <= '0;
      a_mask_q     <= '0;
      a_data_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      proto_err_q  <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      a_valid_q    <= a_valid_d;
      a_opcode_q   <= a_opcode_d;
      a_size_q     <= a_size_d;
      a_source_q   <= a_source_d;
      a_address_q  <= a_address_d;
      a_mask_q     <= a_mask_d;
      a_data_q     <= a_data_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      proto_err_q  <= proto_err_d;
      live_q       <= 1'b1;
    end
  end

`ifdef TLM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;

  // Watchdog: count stalled cycles with work outstanding; abandon everything at the limit
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    flush     = 1'b0;
    if (d_fire || !pend_any) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      flush     = 1'b1;
      timeout_d = 1'b1;
      to_cnt_d  = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  // Watchdog counter and sticky flag
  always_ff @(posedge tlm_clock_i or posedge tlm_reset_i) begin
    if (tlm_reset_i) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, pend_any};
  assign flush      = 1'b0;
`endif

  assign bus.tlm_a_valid   = a_valid_q;
  assign bus.tlm_a_opcode  = a_opcode_q;
  assign bus.tlm_a_param   = '0;
  assign bus.tlm_a_size    = a_size_q;
  assign bus.tlm_a_source  = a_source_q;
  assign bus.tlm_a_address = a_address_q;
  assign bus.tlm_a_mask    = a_mask_q;
  assign bus.tlm_a_data    = a_data_q;
  assign bus.tlm_a_corrupt = 1'b0;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_tag   = resp_tag_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_error = resp_error_q;
  assign proto_err_o    = proto_err_q;

endmodule
